// File: rtl/disp_pkg.sv
// Shared definitions for the display-sharing arbiter: FSM encoding,
// display clock rate, default dwell and the display word width.
package disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWITCH = 2'd1,
    ST_SHOW   = 2'd2
  } disp_state_e;

  // Display datapath runs at 10 MHz
  localparam int DISP_CLK_HZ   = 10_000_000;

  // One second per requester at the display clock rate
  localparam int DEFAULT_DWELL = DISP_CLK_HZ;

  // Width of the word fed to the DigiNumber pair
  localparam int WORD_W        = 32;

endpackage

// File: rtl/disp_share_arbiter_rr_pick.sv
// Round-robin winner search: the requester just after cur_idx has the
// highest priority, cur_idx itself the lowest. Purely combinational.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   cur_idx,
  output logic            found,
  output logic [IW-1:0]   win_idx
);

  logic [IW:0]      start;
  logic [NREQ-1:0]  rot;
  logic [IW:0]      pos;
  logic [IW:0]      sum;

  // Rotate so the search start sits at bit 0, encode the lowest set bit,
  // then add the rotation back (mod NREQ) to get the real index.
  always_comb begin
    start = {1'b0, cur_idx} + (IW+1)'(1);
    if (start >= (IW+1)'(NREQ)) begin
      start = '0;
    end
    rot   = NREQ'({req, req} >> start);
    found = |rot;
    pos   = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        pos = (IW+1)'(j);
      end
    end
    sum = start + pos;
    if (sum >= (IW+1)'(NREQ)) begin
      sum = sum - (IW+1)'(NREQ);
    end
    win_idx = IW'(sum);
  end

endmodule

// File: rtl/disp_share_arbiter.sv
// Time-shares the 32-bit seven-segment display word between NREQ
// requesters: round-robin with a programmable dwell, manual next/hold,
// and immediate hand-over when the displayed requester drops out.
module disp_share_arbiter
  import disp_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DWELL = DEFAULT_DWELL,
  parameter int CW    = 24,
  parameter int IW    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*WORD_W-1:0] req_data,
  input  logic                   hold,
  input  logic                   next,
  output logic [WORD_W-1:0]      data_out,
  output logic                   we,
  output logic [NREQ-1:0]        grant,
  output logic [IW-1:0]          cur_idx
);

  disp_state_e          state_q;
  logic [NREQ-1:0]      grant_q;
  logic [WORD_W-1:0]    data_q;
  logic                 we_q;
  logic [IW-1:0]        idx_q;
  logic [CW-1:0]        cnt_q;

  logic                 pick_found;
  logic [IW-1:0]        pick_idx;
  logic [WORD_W-1:0]    owner_word;
  logic [WORD_W-1:0]    win_word;
  logic                 owner_req;
  logic                 others_req;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req     (req),
    .cur_idx (idx_q),
    .found   (pick_found),
    .win_idx (pick_idx)
  );

  // Word of the current owner and of the round-robin candidate
  assign owner_word = req_data[idx_q*WORD_W +: WORD_W];
  assign win_word   = req_data[pick_idx*WORD_W +: WORD_W];

  // Is the owner still asking, and is anybody else waiting for a turn
  assign owner_req  = req[idx_q];
  assign others_req = |(req & ~(NREQ'(1) << idx_q));

  // Arbiter FSM with dwell counter; every output comes straight from a flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            state_q <= ST_SWITCH;
          end
        end

        ST_SWITCH: begin
          // Grant moves in one step, so two bits are never set together
          if (pick_found) begin
            grant_q <= NREQ'(1) << pick_idx;
            idx_q   <= pick_idx;
            data_q  <= win_word;
            we_q    <= 1'b1;
            cnt_q   <= CW'(DWELL - 1);
            state_q <= ST_SHOW;
          end else begin
            grant_q <= '0;
            state_q <= ST_IDLE;
          end
        end

        ST_SHOW: begin
          // Follow the owner's word; strobe only when it actually changes
          data_q <= owner_word;
          we_q   <= (owner_word != data_q);
          if (!owner_req || next) begin
            state_q <= ST_SWITCH;
          end else if ((cnt_q == '0) && !hold) begin
            if (others_req) begin
              state_q <= ST_SWITCH;
            end else begin
              cnt_q <= CW'(DWELL - 1);
            end
          end else if (!hold) begin
            cnt_q <= cnt_q - CW'(1);
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign data_out = data_q;
  assign we       = we_q;
  assign grant    = grant_q;
  assign cur_idx  = idx_q;

endmodule

// File: tb/tb_disp_share_arbiter.sv
// Scoreboard bench for disp_share_arbiter: a driver applies directed and
// random stimulus on the falling edge and pushes the predicted outputs of
// the next rising edge; a monitor pops and compares after each rising edge.
module tb_disp_share_arbiter;

  localparam int NREQ  = 4;
  localparam int DWELL = 4;
  localparam int CW    = 8;
  localparam int IW    = 2;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*32-1:0]   req_data;
  logic                 hold;
  logic                 next;
  logic [31:0]          data_out;
  logic                 we;
  logic [NREQ-1:0]      grant;
  logic [IW-1:0]        cur_idx;

  disp_share_arbiter #(
    .NREQ  (NREQ),
    .DWELL (DWELL),
    .CW    (CW),
    .IW    (IW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .hold     (hold),
    .next     (next),
    .data_out (data_out),
    .we       (we),
    .grant    (grant),
    .cur_idx  (cur_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0] g;
    logic [31:0]     d;
    logic            w;
    logic [IW-1:0]   i;
  } exp_t;

  exp_t exp_q[$];

  int vectors   = 0;
  int miscompares = 0;

  logic [31:0] words [NREQ];

  // Reference model: who is on screen, how many shown cycles are left,
  // and whether a fresh round-robin choice is due at the coming edge.
  bit              m_live;
  bit              m_pick;
  int              m_idx;
  int              m_left;
  logic [NREQ-1:0] e_grant;
  logic [31:0]     e_data;
  logic            e_we;

  task automatic model_step();
    exp_t e;
    if (rst) begin
      m_live = 0; m_pick = 0; m_idx = 0; m_left = 0;
      e_grant = '0; e_data = '0; e_we = 1'b0;
    end else begin
      e_we = 1'b0;
      if (m_pick) begin
        int  w;
        bit  got;
        got = 0; w = 0;
        for (int k = 1; k <= NREQ; k++) begin
          int c;
          c = (m_idx + k) % NREQ;
          if (!got && req[c]) begin
            got = 1; w = c;
          end
        end
        if (got) begin
          m_idx   = w;
          e_grant = '0;
          e_grant[w] = 1'b1;
          e_data  = words[w];
          e_we    = 1'b1;
          m_left  = DWELL;
          m_live  = 1;
        end else begin
          e_grant = '0;
          m_live  = 0;
        end
        m_pick = 0;
      end else if (m_live) begin
        e_we   = (words[m_idx] != e_data);
        e_data = words[m_idx];
        if (!req[m_idx] || next) begin
          m_pick = 1;
        end else if (!hold) begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            logic [NREQ-1:0] others;
            others = req;
            others[m_idx] = 1'b0;
            if (others != '0) m_pick = 1;
            else m_left = DWELL;
          end
        end
      end else if (req != '0) begin
        m_pick = 1;
      end
    end
    e.g = e_grant; e.d = e_data; e.w = e_we; e.i = IW'(m_idx);
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [NREQ-1:0] rq, input logic hd,
                      input logic nx, input logic rs);
    @(negedge clk);
    rst  = rs;
    req  = rq;
    hold = hd;
    next = nx;
    for (int i = 0; i < NREQ; i++) req_data[i*32 +: 32] = words[i];
    model_step();
  endtask

  // Run until the model shows the requested owner, bounded
  task automatic steer(input int idx, input logic [NREQ-1:0] rq);
    int n;
    n = 0;
    while (!(m_live && !m_pick && m_idx == idx) && n < 60) begin
      step(rq, 1'b0, 1'b0, 1'b0);
      n++;
    end
    if (n >= 60) begin
      vectors++;
      miscompares++;
      $display("FAIL steer: owner %0d not reached, actual model owner %0d", idx, m_idx);
    end
  endtask

  // Monitor: compare every registered output against the scoreboard head
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        vectors++;
        if (grant !== e.g || data_out !== e.d || we !== e.w || cur_idx !== e.i) begin
          miscompares++;
          $display("FAIL outputs @%0t: grant=%b data_out=%h we=%b cur_idx=%0d, required grant=%b data_out=%h we=%b cur_idx=%0d",
                   $time, grant, data_out, we, cur_idx, e.g, e.d, e.w, e.i);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; req = '0; hold = 1'b0; next = 1'b0; req_data = '0;
    for (int i = 0; i < NREQ; i++) words[i] = 32'h1111_1111 * (i + 1);

    // Reset, then latency from IDLE with a single requester
    step('0, 0, 0, 1);
    step('0, 0, 0, 1);
    step('0, 0, 0, 0);
    repeat (8) step(4'b0100, 0, 0, 0);

    // Rotation across 0,1,3 with the dwell expiring
    repeat (24) step(4'b1011, 0, 0, 0);

    // Hold on owner 1 for 20 cycles, then next while still holding
    steer(1, 4'b1011);
    repeat (20) step(4'b1011, 1, 0, 0);
    step(4'b1011, 1, 1, 0);
    repeat (4) step(4'b1011, 1, 0, 0);
    repeat (4) step(4'b1011, 0, 0, 0);

    // Owner 0 drops at the same time as next: one hand-over to 1
    steer(0, 4'b1011);
    step(4'b1010, 0, 1, 0);
    repeat (4) step(4'b1010, 0, 0, 0);
    repeat (5) step('0, 0, 0, 0);

    // Data tracking on a sole requester, including dwell re-selection
    words[0] = 32'h0000_00AB;
    steer(0, 4'b0001);
    step(4'b0001, 0, 0, 0);
    words[0] = 32'h0000_00AC;
    repeat (10) step(4'b0001, 0, 0, 0);

    // Reset asserted mid-SHOW must clear outputs without waiting for a clock
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (grant !== '0 || data_out !== '0 || we !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: grant=%b data_out=%h we=%b, required 0/0/0", grant, data_out, we);
    end
    model_step();
    step('0, 0, 0, 1);
    repeat (5) step('0, 0, 0, 0);

    // Randomised traffic
    for (int i = 0; i < NREQ; i++) words[i] = $urandom;
    for (int c = 0; c < 1500; c++) begin
      logic [NREQ-1:0] rq;
      rq = req;
      if ($urandom_range(0, 5) == 0) rq = NREQ'($urandom);
      if ($urandom_range(0, 3) == 0) words[$urandom_range(0, NREQ-1)] = $urandom;
      step(rq, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 399) == 0));
    end
    step(req, 0, 0, 0);

    @(posedge clk);
    #5;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
